stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Sequencing controller for the stopwatch time datapath. Runs the run/pause/clear/adjust
//  state machine, divides clk down to a 1 s tick, and keeps the MM:SS value as four BCD digits.
//  The digit outputs feed the 4-digit display block. disp_en_min/disp_en_sec blank the field
//  being edited so that it blinks in adjust mode.
// PARAMETERS
//  TICK_DIV  100_000_000  clk cycles per second tick; must be >= 4 and even
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  rst_n        in   1  synchronous, active-low reset
//  btn_start    in   1  start/stop request, 1-cycle pulse, already debounced
//  btn_clear    in   1  clear-time request, 1-cycle pulse
//  btn_adj      in   1  enter/leave adjust mode, 1-cycle pulse
//  btn_sel      in   1  adjust only: toggle edited field (0=min, 1=sec), 1-cycle pulse
//  btn_inc      in   1  adjust only: increment edited field, 1-cycle pulse
//  min_l        out  5  minutes tens digit, 0-5 (bit 4 always 0)
//  min_r        out  5  minutes units digit, 0-9
//  sec_l        out  5  seconds tens digit, 0-5
//  sec_r        out  5  seconds units digit, 0-9
//  running      out  1  1 while state==RUN
//  adj_mode     out  1  1 while state==ADJUST
//  adj_field    out  1  edited field, 0=min, 1=sec
//  disp_en_min  out  1  0 blanks the minutes digits
//  disp_en_sec  out  1  0 blanks the seconds digits
//  rollover     out  1  1-cycle pulse when time wraps from 59:59 to 00:00
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, all digits 0, tick_cnt=0, adj_field=0,
//    disp_en_*=1, blink phase=1, running=adj_mode=rollover=0.
//  States: IDLE (time 00:00, stopped), RUN, PAUSE, ADJUST. All outputs are registered.
//  Pulse priority in a single cycle: clear > start > adj > sel > inc; lower-priority pulses that cycle are dropped.
//  IDLE  : start->RUN; adj->ADJUST (adj_field<=0); clear->IDLE.
//  RUN   : start->PAUSE; clear->IDLE and time<=00:00; adj, sel and inc ignored.
//  PAUSE : start->RUN; clear->IDLE and time<=00:00; adj->ADJUST (adj_field<=0).
//  ADJUST: clear->time<=00:00, stay ADJUST; start->RUN; adj->PAUSE, or IDLE if time==00:00;
//          sel->adj_field toggles; inc->edited field +1, wrapping 59->00, no carry to the other field.
//  Prescaler tick_cnt (0..TICK_DIV-1):
//    - counts only in RUN; holds in PAUSE, so the fractional second is kept on resume;
//    - forced to 0 on clear, in IDLE and on entry to ADJUST.
//  Tick = (state==RUN && tick_cnt==TICK_DIV-1). On that edge tick_cnt<=0 and time advances 1 s.
//    First advance happens exactly TICK_DIV cycles after the edge that sampled start from IDLE.
//  Time advance is a BCD cascade:
//    - sec_r 9->0 carries into sec_l; sec_l 5->0 carries into min_r;
//    - min_r 9->0 carries into min_l; min_l 5->0 on 59:59->00:00;
//    - on the wrap, rollover=1 for exactly one cycle and counting continues.
//  Tick in the same cycle as start in RUN: the tick is applied (time advances), state->PAUSE, tick_cnt<=0.
//  Tick in the same cycle as clear: clear wins, time=00:00, no rollover.
//  Blink: in ADJUST a second counter toggles the blink phase every TICK_DIV/2 cycles.
//    - counter and phase reset on ADJUST entry, phase starts at 1 (visible);
//    - edited field enable = phase, other field enable = 1; the phase resets to 1 on sel or inc
//      so the new value shows immediately;
//    - outside ADJUST both enables are 1.
//  rst_n low mid-count or mid-adjust: full reset state on that edge, with no pulse outputs.
// TESTING (TICK_DIV=10)
//  reset, start, run 600 ticks -> time reaches 10:00; first sec_r=1 exactly 10 cycles after start edge
//  preload 59:58 via ADJUST, start, 2 ticks -> 59:59 then 00:00 with rollover high 1 cycle
//  RUN, start at tick_cnt=4, wait 20 cycles, start -> next advance 6 cycles later (fraction held)
//  start and clear in same cycle during RUN -> IDLE, 00:00, running=0
//  ADJUST: inc x61 on min -> min 01; sel, inc x60 on sec -> sec 00, min unchanged; blink period 10 cycles
//  rst_n=0 for 1 cycle in RUN at 12:34 -> 00:00, IDLE, disp_en_*=1 on next edge

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch sequencer: run/pause/clear/adjust FSM, 1 s prescaler, BCD time and adjust blink.
// States: IDLE stopped at 00:00 | RUN counting | PAUSE held, fraction kept | ADJUST editing a field
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_adj,
  input  logic       btn_sel,
  input  logic       btn_inc,
  output logic [4:0] min_l,
  output logic [4:0] min_r,
  output logic [4:0] sec_l,
  output logic [4:0] sec_r,
  output logic       running,
  output logic       adj_mode,
  output logic       adj_field,
  output logic       disp_en_min,
  output logic       disp_en_sec,
  output logic       rollover
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, ADJUST = 2'd3} state_t;

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'(TICK_DIV / 2 - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] tick_cnt, tick_cnt_nxt, blink_cnt, blink_cnt_nxt;
  logic [7:0]    min_q, min_nxt, sec_q, sec_nxt;
  logic          field_nxt, phase, phase_nxt, roll_nxt;
  logic          p_clear, p_start, p_adj, p_sel, p_inc;
  logic          tick, sec_wrap, min_wrap;

  // Packed BCD {tens, units} incremented modulo 60.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
    if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
    return 8'h00;
  endfunction

  assign p_clear  = btn_clear;
  assign p_start  = btn_start & ~btn_clear;
  assign p_adj    = btn_adj & ~btn_start & ~btn_clear;
  assign p_sel    = btn_sel & ~btn_adj & ~btn_start & ~btn_clear;
  assign p_inc    = btn_inc & ~btn_sel & ~btn_adj & ~btn_start & ~btn_clear;
  assign tick     = (state == RUN) && (tick_cnt == TICK_LAST);
  assign sec_wrap = (sec_q == 8'h59);
  assign min_wrap = (min_q == 8'h59);

  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    min_nxt       = min_q;
    sec_nxt       = sec_q;
    field_nxt     = adj_field;
    blink_cnt_nxt = blink_cnt;
    phase_nxt     = phase;
    roll_nxt      = 1'b0;
    if (p_clear) begin
      min_nxt      = 8'h00;
      sec_nxt      = 8'h00;
      tick_cnt_nxt = '0;
      if (state != ADJUST) state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          tick_cnt_nxt = '0;
          if (p_start) state_nxt = RUN;
          else if (p_adj) begin
            state_nxt = ADJUST;
            field_nxt = 1'b0;
          end
        end
        RUN: begin
          // A pause edge holds the count so the fractional second survives.
          if (tick) begin
            sec_nxt      = inc60(sec_q);
            if (sec_wrap) min_nxt = inc60(min_q);
            roll_nxt     = sec_wrap & min_wrap;
            tick_cnt_nxt = '0;
          end else if (!p_start) tick_cnt_nxt = tick_cnt + 1'b1;
          if (p_start) state_nxt = PAUSE;
        end
        PAUSE: begin
          if (p_start) state_nxt = RUN;
          else if (p_adj) begin
            state_nxt    = ADJUST;
            field_nxt    = 1'b0;
            tick_cnt_nxt = '0;
          end
        end
        ADJUST: begin
          tick_cnt_nxt = '0;
          if (p_start) state_nxt = RUN;
          else if (p_adj) state_nxt = (min_q == 8'h00 && sec_q == 8'h00) ? IDLE : PAUSE;
          else if (p_sel) field_nxt = ~adj_field;
          else if (p_inc) begin
            if (adj_field) sec_nxt = inc60(sec_q);
            else min_nxt = inc60(min_q);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (state_nxt != ADJUST || state != ADJUST || p_sel || p_inc) begin
      blink_cnt_nxt = '0;
      phase_nxt     = 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt_nxt = '0;
      phase_nxt     = ~phase;
    end else begin
      blink_cnt_nxt = blink_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      blink_cnt   <= '0;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      adj_field   <= 1'b0;
      phase       <= 1'b1;
      running     <= 1'b0;
      adj_mode    <= 1'b0;
      disp_en_min <= 1'b1;
      disp_en_sec <= 1'b1;
      rollover    <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_cnt_nxt;
      blink_cnt   <= blink_cnt_nxt;
      min_q       <= min_nxt;
      sec_q       <= sec_nxt;
      adj_field   <= field_nxt;
      phase       <= phase_nxt;
      running     <= (state_nxt == RUN);
      adj_mode    <= (state_nxt == ADJUST);
      disp_en_min <= phase_nxt | ~((state_nxt == ADJUST) & ~field_nxt);
      disp_en_sec <= phase_nxt | ~((state_nxt == ADJUST) & field_nxt);
      rollover    <= roll_nxt;
    end
  end

  assign min_l = {1'b0, min_q[7:4]};
  assign min_r = {1'b0, min_q[3:0]};
  assign sec_l = {1'b0, sec_q[7:4]};
  assign sec_r = {1'b0, sec_q[3:0]};
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10; expected values are hand-computed.
module tb_stopwatch_ctrl;
  localparam logic [4:0] B_START = 5'b00001;
  localparam logic [4:0] B_CLEAR = 5'b00010;
  localparam logic [4:0] B_ADJ   = 5'b00100;
  localparam logic [4:0] B_SEL   = 5'b01000;
  localparam logic [4:0] B_INC   = 5'b10000;

  logic       clk, rst_n;
  logic       btn_start, btn_clear, btn_adj, btn_sel, btn_inc;
  logic [4:0] min_l, min_r, sec_l, sec_r;
  logic       running, adj_mode, adj_field, disp_en_min, disp_en_sec, rollover;
  logic [15:0] tm;
  int n_tot = 0;
  int n_bad = 0;

  stopwatch_ctrl #(.TICK_DIV(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_adj(btn_adj),
    .btn_sel(btn_sel), .btn_inc(btn_inc),
    .min_l(min_l), .min_r(min_r), .sec_l(sec_l), .sec_r(sec_r),
    .running(running), .adj_mode(adj_mode), .adj_field(adj_field),
    .disp_en_min(disp_en_min), .disp_en_sec(disp_en_sec), .rollover(rollover)
  );

  assign tm = {min_l[3:0], min_r[3:0], sec_l[3:0], sec_r[3:0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [4:0] m);
    {btn_inc, btn_sel, btn_adj, btn_clear, btn_start} = m;
    @(posedge clk);
    #1;
    {btn_inc, btn_sel, btn_adj, btn_clear, btn_start} = 5'b0;
  endtask

  task automatic press_n(input logic [4:0] m, input int n);
    repeat (n) press(m);
  endtask

  initial begin
    rst_n = 1'b0;
    {btn_inc, btn_sel, btn_adj, btn_clear, btn_start} = 5'b0;
    step(3);
    chk("rst_time", tm, 16'h0000);
    chk("rst_running", 16'(running), 16'd0);
    chk("rst_adj_mode", 16'(adj_mode), 16'd0);
    chk("rst_field", 16'(adj_field), 16'd0);
    chk("rst_en_min", 16'(disp_en_min), 16'd1);
    chk("rst_en_sec", 16'(disp_en_sec), 16'd1);
    chk("rst_rollover", 16'(rollover), 16'd0);
    rst_n = 1'b1;

    // first advance exactly 10 cycles after the start edge, then 600 s
    press(B_START);
    chk("run_running", 16'(running), 16'd1);
    step(9);
    chk("first_adv_early", tm, 16'h0000);
    step(1);
    chk("first_adv", tm, 16'h0001);
    step(5990);
    chk("ten_min", tm, 16'h1000);
    press(B_CLEAR);
    chk("clear_time", tm, 16'h0000);
    chk("clear_running", 16'(running), 16'd0);

    // tick coinciding with clear: clear wins
    press(B_START);
    step(9);
    press(B_CLEAR);
    chk("tick_clear_time", tm, 16'h0000);

    // tick coinciding with start: advance, pause, prescaler restarts
    press(B_START);
    step(9);
    press(B_START);
    chk("tick_start_time", tm, 16'h0001);
    chk("tick_start_paused", 16'(running), 16'd0);
    step(30);
    chk("paused_hold", tm, 16'h0001);
    press(B_START);
    step(9);
    chk("resume_early", tm, 16'h0001);
    step(1);
    chk("resume_adv", tm, 16'h0002);
    press(B_CLEAR);

    // pause at tick_cnt=4 keeps the fraction
    press(B_START);
    step(4);
    press(B_START);
    chk("frac_paused", 16'(running), 16'd0);
    step(20);
    chk("frac_hold", tm, 16'h0000);
    press(B_START);
    step(5);
    chk("frac_early", tm, 16'h0000);
    step(1);
    chk("frac_adv", tm, 16'h0001);
    press(B_CLEAR);

    // start and clear together in RUN
    press(B_START);
    step(25);
    chk("pre_sc_time", tm, 16'h0002);
    press(B_START | B_CLEAR);
    chk("sc_running", 16'(running), 16'd0);
    chk("sc_time", tm, 16'h0000);
    step(15);
    chk("sc_idle_hold", tm, 16'h0000);

    // adjust: min wrap, sel, blink, sec wrap
    press(B_ADJ);
    chk("adj_enter", 16'(adj_mode), 16'd1);
    chk("adj_field0", 16'(adj_field), 16'd0);
    chk("adj_en_min", 16'(disp_en_min), 16'd1);
    press_n(B_INC, 61);
    chk("inc61_min", tm, 16'h0100);
    press(B_SEL);
    chk("sel_field", 16'(adj_field), 16'd1);
    chk("blink_0", 16'(disp_en_sec), 16'd1);
    step(4);
    chk("blink_4", 16'(disp_en_sec), 16'd1);
    step(1);
    chk("blink_5", 16'(disp_en_sec), 16'd0);
    chk("blink_other", 16'(disp_en_min), 16'd1);
    step(4);
    chk("blink_9", 16'(disp_en_sec), 16'd0);
    step(1);
    chk("blink_10", 16'(disp_en_sec), 16'd1);
    press_n(B_INC, 60);
    chk("inc60_sec", tm, 16'h0100);
    press(B_CLEAR);
    chk("adj_clear_time", tm, 16'h0000);
    chk("adj_clear_stay", 16'(adj_mode), 16'd1);
    press(B_ADJ);
    chk("adj_exit_idle", 16'(adj_mode), 16'd0);

    // preload 59:58 and roll over
    press(B_ADJ);
    press_n(B_INC, 59);
    press(B_SEL);
    press_n(B_INC, 58);
    chk("preload", tm, 16'h5958);
    press(B_START);
    chk("adj_start_run", 16'(running), 16'd1);
    chk("adj_start_mode", 16'(adj_mode), 16'd0);
    step(10);
    chk("t_5959", tm, 16'h5959);
    chk("roll_low", 16'(rollover), 16'd0);
    step(10);
    chk("t_wrap", tm, 16'h0000);
    chk("roll_high", 16'(rollover), 16'd1);
    step(1);
    chk("roll_pulse", 16'(rollover), 16'd0);
    chk("roll_still_run", 16'(running), 16'd1);
    press(B_CLEAR);

    // adjust exit to PAUSE with non-zero time, then resume
    press(B_ADJ);
    press(B_INC);
    press(B_SEL);
    press(B_INC);
    press(B_ADJ);
    chk("adj_pause_mode", 16'(adj_mode), 16'd0);
    chk("adj_pause_run", 16'(running), 16'd0);
    press(B_START);
    step(10);
    chk("pause_resume", tm, 16'h0102);
    press(B_CLEAR);

    // synchronous reset mid-run at 12:34
    press(B_ADJ);
    press_n(B_INC, 12);
    press(B_SEL);
    press_n(B_INC, 34);
    chk("preload_1234", tm, 16'h1234);
    press(B_START);
    step(3);
    chk("pre_rst_run", 16'(running), 16'd1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mid_rst_time", tm, 16'h0000);
    chk("mid_rst_running", 16'(running), 16'd0);
    chk("mid_rst_field", 16'(adj_field), 16'd0);
    chk("mid_rst_en_min", 16'(disp_en_min), 16'd1);
    chk("mid_rst_en_sec", 16'(disp_en_sec), 16'd1);
    step(20);
    chk("mid_rst_idle", tm, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
